window_buffer: RTL and testbench
================================

WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 SHALL have parameter P_SUBPIXEL_DEPTH, default 8: grayscale pixel width in bits.
REQ-002 SHALL have parameter P_IMAGE_WIDTH, default 640: pixels per row, legal range 3..4096.
REQ-003 SHALL have parameter P_IMAGE_HEIGHT, default 480: rows per frame, legal range 3..4096.
REQ-004 SHALL have port I_CLK  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port I_RESET  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port I_PIXEL  input  P_SUBPIXEL_DEPTH: grayscale pixel from the grayscale stage, raster order.
REQ-007 SHALL have port I_VALID  input  1: I_PIXEL is accepted on every cycle this is high; there is no backpressure.
REQ-008 SHALL have port O_WINDOW  output  9*P_SUBPIXEL_DEPTH: 3x3 window; element k=3*r+c occupies [k*P_SUBPIXEL_DEPTH +: P_SUBPIXEL_DEPTH]; r=0 is the oldest row and c=0 the leftmost column.
REQ-009 SHALL have port O_VALID  output  1: O_WINDOW holds a complete window this cycle.

Function
REQ-010 SHALL track column counter col (0..P_IMAGE_WIDTH-1) and row counter row (0..P_IMAGE_HEIGHT-1), advancing only on accepted pixels.
REQ-011 SHALL increment col by one per accepted pixel; at P_IMAGE_WIDTH-1 it SHALL wrap to 0 and increment row.
REQ-012 SHALL wrap row from P_IMAGE_HEIGHT-1 to 0 on the last pixel, so the next accepted pixel starts a new frame with no idle cycle.
REQ-013 SHALL hold two line buffers of P_IMAGE_WIDTH entries each, containing rows row-1 and row-2 at column col.
REQ-014 SHALL shift a 3x3 register array left by one column per accepted pixel, loading the new right column {line2[col], line1[col], I_PIXEL}.
REQ-015 SHALL implement FSM states S_FILL (row<2), S_RUN (row>=2) and S_DONE (one cycle after the last frame pixel); transitions: S_FILL->S_RUN on the first accepted pixel of row 2; S_RUN->S_DONE on acceptance of pixel (P_IMAGE_HEIGHT-1, P_IMAGE_WIDTH-1); S_DONE->S_FILL unconditionally next cycle, or ->S_FILL with the pixel counted as (0,0) if I_VALID is high in S_DONE.
REQ-016 SHALL assert O_VALID exactly one cycle after accepting a pixel with row>=2 and col>=2; the window is centred at (row-1, col-1) and element 8 equals that pixel.
REQ-017 SHALL emit no window for border centres; each frame SHALL yield exactly (P_IMAGE_WIDTH-2)*(P_IMAGE_HEIGHT-2) windows.
REQ-018 SHALL hold O_VALID low and leave counters, line buffers and window unchanged on cycles with I_VALID low.
REQ-019 SHALL keep O_WINDOW stable while O_VALID is low.
REQ-020 SHALL never mix data across frames in an emitted window, because no window is emitted while col<2 or row<2.

Reset
REQ-021 SHALL, on I_RESET low, immediately clear col, row, O_VALID, O_WINDOW and the 3x3 array to 0 and force S_FILL.
REQ-022 SHALL leave line buffer contents unreset.
REQ-023 SHALL treat the first pixel accepted after reset deassertion as (0,0), including after a reset applied mid-frame.

Configuration
REQ-024 SHALL, with WINDOW_BUFFER_FRAME_DONE_EN defined, add output O_FRAME_DONE (1 bit, reset 0), pulsed high for exactly the S_DONE cycle, coincident with the frame's last O_VALID.
REQ-025 SHALL, without WINDOW_BUFFER_FRAME_DONE_EN, have no O_FRAME_DONE port and no S_DONE-dependent logic beyond the transition to S_FILL.

Structure
REQ-026 SHALL place the FSM state enum and the window index constants (WIN_CENTER=4, WIN_TAPS=9) in shared package edge_detection_pkg.
REQ-027 SHALL implement each line buffer as sub-module line_buffer (circular, depth P_IMAGE_WIDTH, shared read/write address col, read-before-write).

Verification (P_IMAGE_WIDTH=4, P_IMAGE_HEIGHT=4, pixel value = 4*row+col)
REQ-028 SHALL check: stream 16 pixels back-to-back -> exactly 4 windows; the first (one cycle after pixel 10) = {0,1,2,4,5,6,8,9,10}; the last = {5,6,7,9,10,11,13,14,15}.
REQ-029 SHALL check: same frame with I_VALID low every other cycle -> identical 4 windows, O_VALID never high in the cycle after a gap cycle.
REQ-030 SHALL check: two frames back-to-back (second frame values +100) -> 8 windows; the 5th = {100,101,102,104,105,106,108,109,110}, with no first-frame values present.
REQ-031 SHALL check: I_RESET low after pixel 9, then a full fresh frame -> no window before the fresh pixel 10; then the 4 correct windows.
REQ-032 SHALL check, with WINDOW_BUFFER_FRAME_DONE_EN defined: O_FRAME_DONE high for exactly one cycle, aligned with the window ending in 15; zero pulses after 15 pixels.

Source files
------------

// File: rtl/edge_detection_pkg.sv
// Shared FSM state type and 3x3 window index constants for the edge-detection pipeline.
package edge_detection_pkg;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } wb_state_e;

    localparam int WIN_DIM    = 3;
    localparam int WIN_TAPS   = 9;
    localparam int WIN_CENTER = 4;

    // Flat tap index of window element (row r, column c); row 0 is the oldest line.
    function automatic int win_index(input int r, input int c);
        return WIN_DIM * r + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Circular single-line store: one shared address, combinational read of the old
// entry and write of the new entry on the same clock edge (read-before-write).
module line_buffer #(
    parameter int P_DATA_W = 8,
    parameter int P_DEPTH  = 640,
    parameter int P_ADDR_W = $clog2(P_DEPTH)
) (
    input  logic                clk_i,
    input  logic                wr_en_i,
    input  logic [P_ADDR_W-1:0] addr_i,
    input  logic [P_DATA_W-1:0] wr_data_i,
    output logic [P_DATA_W-1:0] rd_data_o
);

    logic [P_DATA_W-1:0] mem_q [P_DEPTH];

    assign rd_data_o = mem_q[addr_i];

    // NOTE: the storage array has no reset; a stale line is never emitted because
    // the window stays invalid until two fresh rows have been written.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/window_buffer.sv
// Raster-order 3x3 sliding window generator built on two line buffers.
// Optional O_FRAME_DONE pulse is enabled by defining WINDOW_BUFFER_FRAME_DONE_EN.
module window_buffer
    import edge_detection_pkg::*;
#(
    parameter int P_SUBPIXEL_DEPTH = 8,
    parameter int P_IMAGE_WIDTH    = 640,
    parameter int P_IMAGE_HEIGHT   = 480
) (
    input  logic                                 I_CLK,
    input  logic                                 I_RESET,
    input  logic [P_SUBPIXEL_DEPTH-1:0]          I_PIXEL,
    input  logic                                 I_VALID,
    output logic [WIN_TAPS*P_SUBPIXEL_DEPTH-1:0] O_WINDOW,
    output logic                                 O_VALID
`ifdef WINDOW_BUFFER_FRAME_DONE_EN
    ,
    output logic                                 O_FRAME_DONE
`endif
);

    localparam int COL_W = $clog2(P_IMAGE_WIDTH);
    localparam int ROW_W = $clog2(P_IMAGE_HEIGHT);
    localparam int WIN_W = WIN_TAPS * P_SUBPIXEL_DEPTH;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(P_IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(P_IMAGE_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST_RUN = ROW_W'(2);

    typedef logic [P_SUBPIXEL_DEPTH-1:0] pixel_t;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    wb_state_e        state_q, state_d;
    pixel_t           win_q [WIN_TAPS];
    pixel_t           win_d [WIN_TAPS];
    logic [WIN_W-1:0] window_q, window_d;
    logic             valid_q, valid_d;

    pixel_t line1_rd;
    pixel_t line2_rd;
    logic   col_wrap;
    logic   frame_last;
    logic   emit;

    // line1 holds row-1 and line2 holds row-2; line2 is refilled from line1's old entry.
    line_buffer #(
        .P_DATA_W (P_SUBPIXEL_DEPTH),
        .P_DEPTH  (P_IMAGE_WIDTH),
        .P_ADDR_W (COL_W)
    ) u_line1 (
        .clk_i     (I_CLK),
        .wr_en_i   (I_VALID),
        .addr_i    (col_q),
        .wr_data_i (I_PIXEL),
        .rd_data_o (line1_rd)
    );

    line_buffer #(
        .P_DATA_W (P_SUBPIXEL_DEPTH),
        .P_DEPTH  (P_IMAGE_WIDTH),
        .P_ADDR_W (COL_W)
    ) u_line2 (
        .clk_i     (I_CLK),
        .wr_en_i   (I_VALID),
        .addr_i    (col_q),
        .wr_data_i (line1_rd),
        .rd_data_o (line2_rd)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        col_wrap   = (col_q == COL_LAST);
        frame_last = col_wrap && (row_q == ROW_LAST);
        col_d      = col_q;
        row_d      = row_q;
        if (I_VALID) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: begin
                if (I_VALID && (row_q == ROW_FIRST_RUN) && (col_q == '0)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (I_VALID && frame_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // S_RUN implies row>=2, so only the column border needs masking here.
    assign emit = I_VALID && (state_q == S_RUN) && (col_q >= COL_FIRST_WIN);

    always_comb begin
        for (int k = 0; k < WIN_TAPS; k++) begin
            win_d[k] = win_q[k];
        end
        if (I_VALID) begin
            for (int r = 0; r < WIN_DIM; r++) begin
                win_d[win_index(r, 0)] = win_q[win_index(r, 1)];
                win_d[win_index(r, 1)] = win_q[win_index(r, 2)];
            end
            win_d[win_index(0, 2)] = line2_rd;
            win_d[win_index(1, 2)] = line1_rd;
            win_d[win_index(2, 2)] = I_PIXEL;
        end
    end

    // The output register only loads on emitted windows, keeping O_WINDOW stable otherwise.
    always_comb begin
        window_d = window_q;
        valid_d  = emit;
        if (emit) begin
            for (int k = 0; k < WIN_TAPS; k++) begin
                window_d[k*P_SUBPIXEL_DEPTH +: P_SUBPIXEL_DEPTH] = win_d[k];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge I_CLK or negedge I_RESET) begin
        if (!I_RESET) begin
            col_q    <= '0;
            row_q    <= '0;
            state_q  <= S_FILL;
            window_q <= '0;
            valid_q  <= 1'b0;
            for (int k = 0; k < WIN_TAPS; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            state_q  <= state_d;
            window_q <= window_d;
            valid_q  <= valid_d;
            for (int k = 0; k < WIN_TAPS; k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

    assign O_WINDOW = window_q;
    assign O_VALID  = valid_q;

`ifdef WINDOW_BUFFER_FRAME_DONE_EN
    // S_DONE lasts exactly the cycle carrying the frame's final window.
    assign O_FRAME_DONE = (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_window_buffer.sv
// Self-checking bench for window_buffer on a 4x4 image, against an image-array reference model.
module tb_window_buffer;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int D  = 8;
    localparam int WW = 9 * D;

    logic          clk;
    logic          rst_n;
    logic [D-1:0]  I_PIXEL;
    logic          I_VALID;
    logic [WW-1:0] O_WINDOW;
    logic          O_VALID;
`ifdef WINDOW_BUFFER_FRAME_DONE_EN
    logic          O_FRAME_DONE;
`endif

    window_buffer #(
        .P_SUBPIXEL_DEPTH (D),
        .P_IMAGE_WIDTH    (W),
        .P_IMAGE_HEIGHT   (H)
    ) dut (
        .I_CLK        (clk),
        .I_RESET      (rst_n),
        .I_PIXEL      (I_PIXEL),
        .I_VALID      (I_VALID),
        .O_WINDOW     (O_WINDOW),
        .O_VALID      (O_VALID)
`ifdef WINDOW_BUFFER_FRAME_DONE_EN
        ,
        .O_FRAME_DONE (O_FRAME_DONE)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the current frame as an image, indexed by accepted-pixel count.
    int unsigned   m_idx;
    logic [D-1:0]  m_img [H][W];
    logic          m_exp_valid;
    logic          m_exp_done;
    logic [WW-1:0] m_exp_win;

    int            vectors;
    int            miscompares;
    int            win_count;
    logic [WW-1:0] cap_wins [16];

    function automatic logic [WW-1:0] pack9(input int e0, input int e1, input int e2,
                                            input int e3, input int e4, input int e5,
                                            input int e6, input int e7, input int e8);
        int            e [9];
        logic [WW-1:0] w;
        e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[k*D +: D] = D'(e[k]);
        end
        return w;
    endfunction

    task automatic model_reset();
        m_idx       = 0;
        m_exp_valid = 1'b0;
        m_exp_done  = 1'b0;
        m_exp_win   = '0;
    endtask

    // Drives one clock cycle, advances the model, samples #1 after the edge.
    task automatic step(input logic v, input logic [D-1:0] p);
        int r;
        int c;
        I_VALID = v;
        I_PIXEL = p;
        @(posedge clk);
        m_exp_valid = 1'b0;
        m_exp_done  = 1'b0;
        if (v) begin
            r = int'(m_idx) / W;
            c = int'(m_idx) % W;
            m_img[r][c] = p;
            if (r >= 2 && c >= 2) begin
                m_exp_valid = 1'b1;
                for (int k = 0; k < 9; k++) begin
                    m_exp_win[k*D +: D] = m_img[r - 2 + k / 3][c - 2 + k % 3];
                end
            end
            m_exp_done = (m_idx == W * H - 1);
            m_idx      = (m_idx + 1) % (W * H);
        end
        #1;
        if (O_VALID === 1'b1) begin
            if (win_count < 16) cap_wins[win_count] = O_WINDOW;
            win_count++;
        end
    endtask

    task automatic assert_reset();
        I_VALID = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (O_VALID !== 1'b0 || O_WINDOW !== '0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b win=%h, expected valid=0 win=0", O_VALID, O_WINDOW);
        end
`ifdef WINDOW_BUFFER_FRAME_DONE_EN
        vectors++;
        if (O_FRAME_DONE !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frame_done: got %b, expected 0", O_FRAME_DONE);
        end
`endif
        model_reset();
        release_reset();
    endtask

    task automatic test_single_frame();
        win_count = 0;
        for (int i = 0; i < W * H + 2; i++) begin
            if (i < W * H) step(1'b1, D'(i));
            else           step(1'b0, '0);
            vectors++;
            if (O_VALID !== m_exp_valid || O_WINDOW !== m_exp_win) begin
                miscompares++;
                $display("FAIL single_frame step %0d: valid=%b win=%h, expected valid=%b win=%h",
                         i, O_VALID, O_WINDOW, m_exp_valid, m_exp_win);
            end
        end
        vectors++;
        if (win_count != 4) begin
            miscompares++;
            $display("FAIL single_frame_count: got %0d windows, expected 4", win_count);
        end
        vectors++;
        if (cap_wins[0] !== pack9(0, 1, 2, 4, 5, 6, 8, 9, 10)) begin
            miscompares++;
            $display("FAIL single_frame_first: got %h, expected %h", cap_wins[0], pack9(0, 1, 2, 4, 5, 6, 8, 9, 10));
        end
        vectors++;
        if (cap_wins[3] !== pack9(5, 6, 7, 9, 10, 11, 13, 14, 15)) begin
            miscompares++;
            $display("FAIL single_frame_last: got %h, expected %h", cap_wins[3], pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
        end
    endtask

    task automatic test_gapped();
        logic [WW-1:0] ref_wins [4];
        for (int j = 0; j < 4; j++) ref_wins[j] = cap_wins[j];
        win_count = 0;
        for (int i = 0; i < W * H; i++) begin
            for (int g = 0; g < 2; g++) begin
                if (g == 0) step(1'b1, D'(i));
                else        step(1'b0, D'($urandom));
                vectors++;
                if (O_VALID !== m_exp_valid || O_WINDOW !== m_exp_win) begin
                    miscompares++;
                    $display("FAIL gapped px %0d phase %0d: valid=%b win=%h, expected valid=%b win=%h",
                             i, g, O_VALID, O_WINDOW, m_exp_valid, m_exp_win);
                end
            end
        end
        vectors++;
        if (win_count != 4) begin
            miscompares++;
            $display("FAIL gapped_count: got %0d windows, expected 4", win_count);
        end
        for (int j = 0; j < 4; j++) begin
            vectors++;
            if (cap_wins[j] !== ref_wins[j]) begin
                miscompares++;
                $display("FAIL gapped_window %0d: got %h, expected %h", j, cap_wins[j], ref_wins[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int foreign;
        win_count = 0;
        for (int i = 0; i < 2 * W * H; i++) begin
            step(1'b1, (i < W * H) ? D'(i) : D'(100 + i - W * H));
            vectors++;
            if (O_VALID !== m_exp_valid || O_WINDOW !== m_exp_win) begin
                miscompares++;
                $display("FAIL back_to_back px %0d: valid=%b win=%h, expected valid=%b win=%h",
                         i, O_VALID, O_WINDOW, m_exp_valid, m_exp_win);
            end
        end
        vectors++;
        if (win_count != 8) begin
            miscompares++;
            $display("FAIL back_to_back_count: got %0d windows, expected 8", win_count);
        end
        vectors++;
        if (cap_wins[4] !== pack9(100, 101, 102, 104, 105, 106, 108, 109, 110)) begin
            miscompares++;
            $display("FAIL back_to_back_fifth: got %h, expected %h",
                     cap_wins[4], pack9(100, 101, 102, 104, 105, 106, 108, 109, 110));
        end
        foreign = 0;
        for (int j = 4; j < 8; j++) begin
            for (int k = 0; k < 9; k++) begin
                if (int'(cap_wins[j][k*D +: D]) < 100) foreign++;
            end
        end
        vectors++;
        if (foreign != 0) begin
            miscompares++;
            $display("FAIL back_to_back_mixing: %0d first-frame values in second-frame windows, expected 0", foreign);
        end
        step(1'b0, '0);
    endtask

    task automatic test_mid_reset();
        win_count = 0;
        for (int i = 0; i < 10; i++) step(1'b1, D'(i));
        assert_reset();
        vectors++;
        if (O_VALID !== 1'b0 || O_WINDOW !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: valid=%b win=%h, expected valid=0 win=0", O_VALID, O_WINDOW);
        end
        release_reset();
        win_count = 0;
        for (int i = 0; i < W * H; i++) begin
            step(1'b1, D'(i));
            vectors++;
            if (O_VALID !== m_exp_valid || O_WINDOW !== m_exp_win) begin
                miscompares++;
                $display("FAIL mid_reset px %0d: valid=%b win=%h, expected valid=%b win=%h",
                         i, O_VALID, O_WINDOW, m_exp_valid, m_exp_win);
            end
            if (i == 9) begin
                vectors++;
                if (win_count != 0) begin
                    miscompares++;
                    $display("FAIL mid_reset_early: got %0d windows before fresh pixel 10, expected 0", win_count);
                end
            end
        end
        vectors++;
        if (win_count != 4 || cap_wins[0] !== pack9(0, 1, 2, 4, 5, 6, 8, 9, 10)
            || cap_wins[3] !== pack9(5, 6, 7, 9, 10, 11, 13, 14, 15)) begin
            miscompares++;
            $display("FAIL mid_reset_windows: count=%0d first=%h last=%h, expected count=4 first=%h last=%h",
                     win_count, cap_wins[0], cap_wins[3],
                     pack9(0, 1, 2, 4, 5, 6, 8, 9, 10), pack9(5, 6, 7, 9, 10, 11, 13, 14, 15));
        end
        step(1'b0, '0);
    endtask

`ifdef WINDOW_BUFFER_FRAME_DONE_EN
    task automatic test_frame_done();
        int pulses;
        pulses = 0;
        for (int i = 0; i < W * H - 1; i++) begin
            step(1'b1, D'(i));
            if (O_FRAME_DONE === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL frame_done_early: %0d pulses after 15 pixels, expected 0", pulses);
        end
        step(1'b1, D'(W * H - 1));
        if (O_FRAME_DONE === 1'b1) pulses++;
        vectors++;
        if (O_FRAME_DONE !== 1'b1 || O_VALID !== 1'b1 || O_WINDOW[8*D +: D] !== D'(15)) begin
            miscompares++;
            $display("FAIL frame_done_align: done=%b valid=%b elem8=%0d, expected done=1 valid=1 elem8=15",
                     O_FRAME_DONE, O_VALID, O_WINDOW[8*D +: D]);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0);
            if (O_FRAME_DONE === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL frame_done_pulses: got %0d pulses, expected 1", pulses);
        end
    endtask
`endif

    task automatic test_random();
        int reset_at;
        reset_at = 40 + int'($urandom_range(30));
        for (int n = 0; n < 160; n++) begin
            if (n == reset_at) begin
                assert_reset();
                release_reset();
            end
            step($urandom_range(2) != 0, D'($urandom));
            vectors++;
            if (O_VALID !== m_exp_valid || O_WINDOW !== m_exp_win) begin
                miscompares++;
                $display("FAIL random step %0d: valid=%b win=%h, expected valid=%b win=%h",
                         n, O_VALID, O_WINDOW, m_exp_valid, m_exp_win);
            end
`ifdef WINDOW_BUFFER_FRAME_DONE_EN
            vectors++;
            if (O_FRAME_DONE !== m_exp_done) begin
                miscompares++;
                $display("FAIL random_frame_done step %0d: got %b, expected %b", n, O_FRAME_DONE, m_exp_done);
            end
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk         = 1'b0;
        rst_n       = 1'b0;
        I_VALID     = 1'b0;
        I_PIXEL     = '0;
        vectors     = 0;
        miscompares = 0;
        win_count   = 0;
        model_reset();

        test_reset();
        test_single_frame();
        test_gapped();
        test_back_to_back();
        test_mid_reset();
`ifdef WINDOW_BUFFER_FRAME_DONE_EN
        test_frame_done();
`endif
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
